dyn_compressor: RTL and testbench
=================================

DYN_COMPRESSOR -- requirements
Module: dyn_compressor

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 16, signed sample width per channel
- CH, 2, channel count; all channels share one linked gain
- LA_DEPTH, 32, lookahead delay in samples; power of 2, >=2
REQ-002 Ports SHALL be (name, direction, width, meaning):
- i_clk, in, 1, clock
- i_rst_n, in, 1, reset, asynchronous, active-low
- i_valid, in, 1, new-sample strobe
- i_enable, in, 1, 0 = bypass
- i_threshold, in, DATA_W-1, unsigned threshold level
- i_ratio, in, 2, 0=2:1, 1=4:1, 2=8:1, 3=limiter
- i_attack_sh, in, 4, gain-down shift
- i_release_sh, in, 4, gain-up shift
- i_makeup, in, 16, unsigned Q4.12 makeup gain
- i_data, in, CH*DATA_W, packed samples, ch0 in LSBs
- o_data, out, CH*DATA_W, processed samples
- o_valid, out, 1, output strobe
- o_gain, out, 16, current gain, unsigned Q1.15, unity = 0x8000
- o_clip, out, 1, pulse with o_valid when any channel saturated
- o_overrun, out, 1, sticky: strobe arrived while divider busy

Function
REQ-003 o_valid SHALL assert exactly one cycle after each i_valid, for one cycle.
REQ-004 Per channel, abs SHALL saturate: abs(min negative) = 2^(DATA_W-1)-1; the linked level SHALL be the maximum abs over all channels.
REQ-005 On each i_valid, the envelope SHALL update as env += (lvl-env)>>>4 when lvl>env, else env -= (env-lvl)>>>4.
REQ-006 If env > i_threshold, the target level SHALL be thr + ((env-thr)>>r), with r = 1/2/3 for i_ratio 0/1/2, and thr for i_ratio 3; otherwise target gain SHALL be 0x8000 with no divide.
REQ-007 target gain = (target_level<<15)/env SHALL be computed by a sequential restoring divider in 16 cycles, launched the cycle after i_valid; result clamped to 0x8000 and loaded on completion.
REQ-008 i_valid arriving while the divider is busy SHALL NOT relaunch it; the sample SHALL be processed normally; o_overrun SHALL set. Strobes spaced >=20 cycles SHALL never cause overrun.
REQ-009 On each i_valid, the current gain SHALL move toward target: g -= (g-t)>>i_attack_sh when g>t; g += (t-g)>>i_release_sh when g<t. A nonzero difference with a zero shifted step SHALL step by 1.
REQ-010 The lookahead buffer SHALL be a circular RAM of LA_DEPTH entries (CH*DATA_W bits). The write pointer SHALL wrap LA_DEPTH-1 -> 0. Output samples SHALL be written LA_DEPTH strobes earlier.
REQ-011 A fill counter SHALL force delayed samples to 0 until LA_DEPTH strobes have been written since reset.
REQ-012 Enabled output per channel SHALL be sat(((x*g)>>>15 * i_makeup)>>>12) with 32-bit signed intermediates. sat SHALL clip to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and set o_clip.
REQ-013 i_enable=0: o_data SHALL be the undelayed i_data and g SHALL be forced to 0x8000. Envelope, buffer and fill counter SHALL keep running, so re-enabling emits no stale buffer contents.
REQ-014 Parameter inputs SHALL be sampled at i_valid; changes between strobes SHALL have no effect until the next strobe.

Reset
REQ-015 While i_rst_n=0: o_data=0, o_valid=0, o_clip=0, o_overrun=0, o_gain=0x8000, env=0, write pointer=0, fill counter=0, divider idle.
REQ-016 Reset asserted mid-divide SHALL abort the divide; no result SHALL load after release.
REQ-017 Buffer RAM contents SHALL NOT require reset; REQ-011 masks them.

Structure
REQ-018 A package dyn_comp_pkg SHALL hold: the ratio enum, GAIN_UNITY (0x8000), the envelope shift (4), and the divider cycle count (16).
REQ-019 The divider SHALL be a sub-module dyn_comp_div with start/busy/done handshake. Everything else SHALL stay in dyn_compressor.

Verification
REQ-020 DATA_W=16, CH=2, LA_DEPTH=4: strobes carrying 100,200,300,400,500 -> outputs 0,0,0,0,100; o_valid one cycle after each strobe.
REQ-021 Constant input 16000 on ch0 and 0 on ch1, thr=8000, i_ratio=3, makeup=0x1000, attack 2 -> o_gain converges to 0x4000 and outputs settle to 8000.
REQ-022 Input -32768 with gain 0x8000 and makeup 0x2000 -> output -32768 with o_clip=1; input +20000 -> output 32767 with o_clip=1.
REQ-023 Strobes spaced 10 cycles -> o_overrun=1 and stays set; strobes spaced 20 cycles from reset -> o_overrun stays 0.
REQ-024 Reset asserted 5 cycles into a divide, then released -> o_gain=0x8000; no divide result appears before the next strobe.
REQ-025 With i_enable=0, input 1234 -> output 1234 after 1 cycle, o_gain=0x8000; after re-enable, delayed data resumes per REQ-010.

Source files
------------

// File: rtl/dyn_comp_pkg.sv
// dyn_comp_pkg: shared ratio encoding, unity gain, envelope shift and divider length for the compressor
package dyn_comp_pkg;
  typedef enum logic [1:0] {RATIO_2_1, RATIO_4_1, RATIO_8_1, RATIO_LIMIT} ratio_e;
  localparam logic [15:0] GAIN_UNITY = 16'h8000;
  localparam int ENV_SH = 4;
  localparam int DIV_CYCLES = 16;
endpackage

// File: rtl/dyn_comp_div.sv
// dyn_comp_div: 16-step restoring divider (i_start/o_busy/o_done), o_quot = i_num / i_den assuming i_num>>16 < i_den
module dyn_comp_div
  import dyn_comp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [DATA_W+13:0] i_num,
  input  logic [DATA_W-2:0]  i_den,
  output logic               o_busy,
  output logic               o_done,
  output logic [15:0]        o_quot
);
  logic [DATA_W-2:0] rem, den;
  logic [DATA_W-1:0] rem_sh;
  logic [15:0] quot;
  logic [4:0] cnt;
  logic ge;
  assign o_quot = quot;
  always_comb begin
    rem_sh = {rem, quot[15]};
    ge = rem_sh >= {1'b0, den};
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      rem <= '0;
      den <= '0;
      quot <= '0;
      cnt <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_start && !o_busy) begin
        rem <= (DATA_W-1)'(i_num[DATA_W+13:16]);
        quot <= i_num[15:0];
        den <= i_den;
        cnt <= 5'(DIV_CYCLES);
        o_busy <= 1'b1;
      end else if (o_busy) begin
        rem <= ge ? (DATA_W-1)'(rem_sh - {1'b0, den}) : rem_sh[DATA_W-2:0];
        quot <= {quot[14:0], ge};
        cnt <= cnt - 5'd1;
        if (cnt == 5'd1) begin
          o_busy <= 1'b0;
          o_done <= 1'b1;
        end
      end
    end
endmodule

// File: rtl/dyn_compressor.sv
// dyn_compressor: linked-gain lookahead compressor (i_valid/i_data in, o_valid/o_data/o_gain/o_clip/o_overrun out)
module dyn_compressor
  import dyn_comp_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int CH       = 2,
  parameter int LA_DEPTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_enable,
  input  logic [DATA_W-2:0]    i_threshold,
  input  logic [1:0]           i_ratio,
  input  logic [3:0]           i_attack_sh,
  input  logic [3:0]           i_release_sh,
  input  logic [15:0]          i_makeup,
  input  logic [CH*DATA_W-1:0] i_data,
  output logic [CH*DATA_W-1:0] o_data,
  output logic                 o_valid,
  output logic [15:0]          o_gain,
  output logic                 o_clip,
  output logic                 o_overrun
);
  localparam int AW = $clog2(LA_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(LA_DEPTH);
  localparam logic signed [31:0] SMAX = 2**(DATA_W-1) - 1;
  localparam logic signed [31:0] SMIN = -(2**(DATA_W-1));
  logic [CH*DATA_W-1:0] la_ram [LA_DEPTH];
  logic [CH*DATA_W-1:0] rd, sat_data;
  logic [AW-1:0] wp;
  logic [AW:0] fill;
  logic [DATA_W-2:0] env, env_nx, thr_q, lvl, abs_c, tl;
  logic [DATA_W-1:0] x, neg;
  logic signed [DATA_W-1:0] xd;
  logic signed [31:0] p1, p2;
  logic [1:0] ratio_q;
  logic [15:0] g, tgt, gd, gs, gst, g_nx, quot;
  logic pend, over, start, busy, done, clip_any;
  assign o_gain = g;
  always_comb begin
    rd = la_ram[wp];
    lvl = '0;
    x = '0;
    neg = '0;
    abs_c = '0;
    xd = '0;
    p1 = '0;
    p2 = '0;
    sat_data = '0;
    clip_any = 1'b0;
    for (int c = 0; c < CH; c++) begin
      x = i_data[c*DATA_W +: DATA_W];
      neg = -x;
      abs_c = !x[DATA_W-1] ? x[DATA_W-2:0] : neg[DATA_W-1] ? '1 : neg[DATA_W-2:0];
      lvl = abs_c > lvl ? abs_c : lvl;
      xd = fill == FULL ? rd[c*DATA_W +: DATA_W] : '0;
      p1 = (32'(xd) * $signed({16'b0, g})) >>> 15;
      p2 = (p1 * $signed({16'b0, i_makeup})) >>> 12;
      sat_data[c*DATA_W +: DATA_W] = p2 > SMAX ? SMAX[DATA_W-1:0] : p2 < SMIN ? SMIN[DATA_W-1:0] : p2[DATA_W-1:0];
      clip_any = clip_any | p2 > SMAX | p2 < SMIN;
    end
  end
  always_comb begin
    env_nx = lvl > env ? env + ((lvl - env) >> ENV_SH) : env - ((env - lvl) >> ENV_SH);
    over = env > thr_q;
    tl = ratio_q == RATIO_LIMIT ? thr_q : thr_q + ((env - thr_q) >> ({1'b0, ratio_q} + 3'd1));
    start = pend && over && !busy;
    gd = g > tgt ? g - tgt : tgt - g;
    gs = g > tgt ? gd >> i_attack_sh : gd >> i_release_sh;
    gst = gs == '0 ? 16'd1 : gs;
    g_nx = g > tgt ? g - gst : g < tgt ? g + gst : g;
  end
  dyn_comp_div #(.DATA_W(DATA_W)) u_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (start),
    .i_num   ({tl, 15'b0}),
    .i_den   (env),
    .o_busy  (busy),
    .o_done  (done),
    .o_quot  (quot)
  );
  always_ff @(posedge i_clk)
    if (i_valid) la_ram[wp] <= i_data;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      o_data <= '0;
      o_valid <= 1'b0;
      o_clip <= 1'b0;
      o_overrun <= 1'b0;
      g <= GAIN_UNITY;
      tgt <= GAIN_UNITY;
      env <= '0;
      thr_q <= '0;
      ratio_q <= '0;
      wp <= '0;
      fill <= '0;
      pend <= 1'b0;
    end else begin
      o_valid <= i_valid;
      pend <= i_valid;
      o_clip <= i_valid && i_enable && clip_any;
      if (i_valid) begin
        o_data <= i_enable ? sat_data : i_data;
        g <= i_enable ? g_nx : GAIN_UNITY;
        env <= env_nx;
        thr_q <= i_threshold;
        ratio_q <= i_ratio;
        wp <= wp + 1'b1;
        fill <= fill == FULL ? fill : fill + 1'b1;
        if (busy || pend) o_overrun <= 1'b1;
      end
      if (pend && !over) tgt <= GAIN_UNITY;
      else if (done) tgt <= quot > GAIN_UNITY ? GAIN_UNITY : quot;
    end
endmodule

// File: tb/tb_dyn_compressor.sv
// tb_dyn_compressor: directed and random strobes checked against an arithmetic reference model
module tb_dyn_compressor;
  logic clk = 0, rst_n = 0, valid = 0, enable = 1;
  logic [14:0] thr = 0;
  logic [1:0] ratio = 0;
  logic [3:0] att = 0, rel = 0;
  logic [15:0] makeup = 16'h1000;
  logic [31:0] din = 0, dout;
  logic ovalid, clip, overrun;
  logic [15:0] gain;
  int checks = 0, failures = 0;
  int m_env, m_g, m_tgt;
  logic [31:0] hist[$];
  logic [31:0] last;
  logic last_clip;
  bit p_en;
  int p_thr, p_ratio, p_att, p_rel, p_mk;
  always #5 clk = ~clk;
  dyn_compressor #(.DATA_W(16), .CH(2), .LA_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_enable(enable),
    .i_threshold(thr), .i_ratio(ratio), .i_attack_sh(att), .i_release_sh(rel),
    .i_makeup(makeup), .i_data(din), .o_data(dout), .o_valid(ovalid),
    .o_gain(gain), .o_clip(clip), .o_overrun(overrun)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic int sabs(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    return s < 0 ? (s == -32768 ? 32767 : -s) : s;
  endfunction
  function automatic logic [15:0] proc(input logic [15:0] xv, input int gv, input int mk, output bit c);
    longint y, z;
    y = (longint'($signed(xv)) * gv) >>> 15;
    z = (y * mk) >>> 12;
    c = z > 32767 || z < -32768;
    if (z > 32767) z = 32767;
    if (z < -32768) z = -32768;
    return 16'(z);
  endfunction
  task automatic model_reset();
    m_env = 0;
    m_g = 32768;
    m_tgt = 32768;
    hist.delete();
  endtask
  task automatic do_reset();
    rst_n = 0;
    @(negedge clk);
    chk("rst_data", dout, 0);
    chk("rst_valid", ovalid, 0);
    chk("rst_clip", clip, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_gain", gain, 16'h8000);
    @(negedge clk);
    rst_n = 1;
    model_reset();
  endtask
  task automatic strobe(input logic [31:0] d, input int gap, input bit do_chk);
    logic [31:0] dl, eo;
    bit c0, c1;
    int lvl, s, tl, q;
    dl = hist.size() >= 4 ? hist[hist.size()-4] : '0;
    c0 = 0;
    c1 = 0;
    eo = d;
    if (p_en) begin
      eo[15:0] = proc(dl[15:0], m_g, p_mk, c0);
      eo[31:16] = proc(dl[31:16], m_g, p_mk, c1);
    end
    if (!p_en) m_g = 32768;
    else if (m_g > m_tgt) begin
      s = (m_g - m_tgt) >> p_att;
      m_g -= (s == 0) ? 1 : s;
    end else if (m_g < m_tgt) begin
      s = (m_tgt - m_g) >> p_rel;
      m_g += (s == 0) ? 1 : s;
    end
    lvl = sabs(d[15:0]) > sabs(d[31:16]) ? sabs(d[15:0]) : sabs(d[31:16]);
    m_env = lvl > m_env ? m_env + ((lvl - m_env) >> 4) : m_env - ((m_env - lvl) >> 4);
    if (m_env > p_thr) begin
      tl = p_ratio == 3 ? p_thr : p_thr + ((m_env - p_thr) >> (p_ratio + 1));
      q = (tl * 32768) / m_env;
      m_tgt = q > 32768 ? 32768 : q;
    end else m_tgt = 32768;
    hist.push_back(d);
    valid = 1;
    din = d;
    enable = p_en;
    thr = 15'(p_thr);
    ratio = 2'(p_ratio);
    att = 4'(p_att);
    rel = 4'(p_rel);
    makeup = 16'(p_mk);
    @(negedge clk);
    if (do_chk) begin
      chk("valid", ovalid, 1);
      chk("data", dout, eo);
      chk("clip", clip, c0 | c1);
      chk("gain", gain, m_g);
    end
    last = dout;
    last_clip = clip;
    valid = 0;
    din = $urandom;
    thr = 15'($urandom);
    ratio = 2'($urandom);
    att = 4'($urandom);
    rel = 4'($urandom);
    makeup = 16'($urandom);
    enable = 1'($urandom);
    @(negedge clk);
    if (do_chk) chk("valid_low", ovalid, 0);
    repeat (gap - 2) @(negedge clk);
  endtask
  initial begin
    int v;
    model_reset();
    p_en = 1; p_thr = 32767; p_ratio = 0; p_att = 0; p_rel = 0; p_mk = 16'h1000;
    @(negedge clk);
    do_reset();
    for (int i = 1; i <= 5; i++) strobe(32'(i * 100), 20, 1);
    chk("la_first_out", last, 100);
    p_mk = 16'h2000;
    repeat (4) strobe(32'h0000_8000, 20, 1);
    strobe(32'd20000, 20, 1);
    chk("neg_sat", last[15:0], 16'h8000);
    chk("neg_clip", last_clip, 1);
    repeat (3) strobe(32'd20000, 20, 1);
    strobe(32'd0, 20, 1);
    chk("pos_sat", last[15:0], 16'h7FFF);
    chk("pos_clip", last_clip, 1);
    do_reset();
    p_thr = 8000; p_ratio = 3; p_mk = 16'h1000; p_att = 2; p_rel = 2;
    repeat (150) strobe(32'd16000, 20, 1);
    chk("gain_conv", gain >= 16'h3FC0 && gain <= 16'h4040, 1);
    v = int'($signed(last[15:0]));
    chk("out_settle", v >= 7960 && v <= 8040, 1);
    p_en = 0;
    strobe(32'd1234, 20, 1);
    chk("bypass_data", last, 1234);
    chk("bypass_gain", gain, 16'h8000);
    strobe(32'h0001_0FFF, 20, 1);
    p_en = 1;
    repeat (6) strobe($urandom, 20, 1);
    do_reset();
    p_thr = 100; p_ratio = 1; p_att = 1; p_rel = 3;
    repeat (6) strobe(32'd20000, 20, 1);
    chk("no_overrun_20", overrun, 0);
    repeat (3) strobe(32'd20000, 10, 0);
    chk("overrun_10", overrun, 1);
    repeat (2) strobe(32'd20000, 25, 0);
    chk("overrun_sticky", overrun, 1);
    do_reset();
    strobe(32'd32000, 2, 1);
    repeat (5) @(negedge clk);
    do_reset();
    repeat (25) @(negedge clk);
    chk("abort_gain", gain, 16'h8000);
    strobe(32'd32000, 20, 1);
    chk("abort_no_load", gain, 16'h8000);
    do_reset();
    for (int i = 0; i < 40; i++) begin
      p_en = $urandom_range(0, 7) != 0;
      p_thr = $urandom_range(0, 32767);
      p_ratio = $urandom_range(0, 3);
      p_att = $urandom_range(0, 15);
      p_rel = $urandom_range(0, 15);
      p_mk = $urandom_range(0, 65535);
      strobe($urandom, $urandom_range(20, 24), 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
